// File: rtl/mem_responder_if.sv
// Memory request/response bus between an LC-3b style initiator and the memory responder.
interface mem_responder_if;
    logic        mem_read;
    logic        mem_write;
    logic [1:0]  mem_byte_enable;
    logic [15:0] mem_address;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic        mem_resp;
    logic        proto_err;

    modport master (
        output mem_read, mem_write, mem_byte_enable, mem_address, mem_wdata,
        input  mem_rdata, mem_resp, proto_err
    );

    modport slave (
        input  mem_read, mem_write, mem_byte_enable, mem_address, mem_wdata,
        output mem_rdata, mem_resp, proto_err
    );
endinterface

// File: rtl/mem_responder.sv
// Memory-side responder: accepts a read/write request, waits LATENCY cycles,
// then completes the access from an internal word array with a one-cycle mem_resp.
module mem_responder #(
    parameter int LATENCY   = 3,
    parameter int ADDR_BITS = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    mem_responder_if.slave  bus
);
    localparam int         DEPTH = 1 << ADDR_BITS;
    localparam logic [3:0] LOAD  = 4'(LATENCY - 1);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

    state_e                 state_q, state_d;
    logic [3:0]             cnt_q, cnt_d;
    logic [ADDR_BITS-1:0]   addr_q, addr_d;
    logic [15:0]            wdata_q, wdata_d;
    logic [1:0]             be_q, be_d;
    logic                   wr_q, wr_d;
    logic [15:0]            rdata_q, rdata_d;
    logic                   perr_q, perr_d;

    // Word array; deliberately not cleared by reset.
    logic [15:0]            mem_q [DEPTH];

    // State and captured-request registers, aborted to IDLE by async reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            wr_q    <= 1'b0;
            rdata_q <= '0;
            perr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            be_q    <= be_d;
            wr_q    <= wr_d;
            rdata_q <= rdata_d;
            perr_q  <= perr_d;
        end
    end

    // Next-state logic: capture in IDLE, count down in WAIT, single RESP cycle.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        be_d    = be_q;
        wr_d    = wr_q;
        perr_d  = perr_q;
        case (state_q)
            IDLE: begin
                if (bus.mem_read | bus.mem_write) begin
                    addr_d  = bus.mem_address[ADDR_BITS:1];
                    wdata_d = bus.mem_wdata;
                    be_d    = bus.mem_byte_enable;
                    // A simultaneous read+write is serviced as a read.
                    wr_d    = bus.mem_write & ~bus.mem_read;
                    perr_d  = perr_q | (bus.mem_write & bus.mem_read);
                    cnt_d   = LOAD;
                    state_d = (LATENCY == 1) ? RESP : WAIT;
                end
            end
            WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) state_d = RESP;
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output logic: read data is registered on entry to RESP so it is valid in that cycle.
    always_comb begin
        rdata_d = rdata_q;
        if (state_d == RESP && !wr_d) rdata_d = mem_q[addr_d];
        bus.mem_resp  = (state_q == RESP);
        bus.mem_rdata = rdata_q;
        bus.proto_err = perr_q;
    end

    // Array write of the enabled byte lanes at the edge closing a write's RESP cycle.
    always_ff @(posedge clk) begin
        if (state_q == RESP && wr_q) begin
            if (be_q[0]) mem_q[addr_q][7:0]  <= wdata_q[7:0];
            if (be_q[1]) mem_q[addr_q][15:8] <= wdata_q[15:8];
        end
    end
endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder: directed cases plus randomized traffic
// checked against a word-array reference model.
module tb_mem_responder;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_err = 0;

    mem_responder_if b3 ();
    mem_responder_if b1 ();

    mem_responder #(.LATENCY(3), .ADDR_BITS(8)) dut3 (.clk(clk), .rst_n(rst_n), .bus(b3));
    mem_responder #(.LATENCY(1), .ADDR_BITS(8)) dut1 (.clk(clk), .rst_n(rst_n), .bus(b1));

    always #5 clk = ~clk;

    // Reference model of the LATENCY=3 instance's array.
    logic [15:0] model [256];
    logic [15:0] last_rd;

    function automatic logic [15:0] merge(input logic [15:0] old, input logic [15:0] nw,
                                          input logic [1:0] be);
        logic [15:0] r;
        r = old;
        if (be[0]) r[7:0]  = nw[7:0];
        if (be[1]) r[15:8] = nw[15:8];
        return r;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic resp_of(input bit sel);
        return sel ? b1.mem_resp : b3.mem_resp;
    endfunction

    // One full transaction; returns the data seen in the resp cycle and the latency.
    task automatic access(input bit sel, input bit rd, input bit wr, input logic [1:0] be,
                          input logic [15:0] a, input logic [15:0] d, input bit perturb,
                          output logic [15:0] rdata, output int lat);
        @(negedge clk);
        if (sel) begin
            b1.mem_read = rd; b1.mem_write = wr; b1.mem_byte_enable = be;
            b1.mem_address = a; b1.mem_wdata = d;
        end else begin
            b3.mem_read = rd; b3.mem_write = wr; b3.mem_byte_enable = be;
            b3.mem_address = a; b3.mem_wdata = d;
        end
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
            if (perturb && lat == 1) begin
                b3.mem_address = 16'($urandom);
                b3.mem_wdata   = 16'($urandom);
                b3.mem_byte_enable = 2'($urandom);
            end
        end while (!resp_of(sel) && lat < 40);
        rdata = sel ? b1.mem_rdata : b3.mem_rdata;
        if (sel) begin b1.mem_read = 1'b0; b1.mem_write = 1'b0; end
        else     begin b3.mem_read = 1'b0; b3.mem_write = 1'b0; end
        @(negedge clk);
        check("resp_one_cycle", {31'd0, resp_of(sel)}, 32'd0);
    endtask

    // Convenience wrappers for the LATENCY=3 instance that also update/check the model.
    task automatic wr3(input logic [15:0] a, input logic [15:0] d, input logic [1:0] be,
                       input bit perturb);
        logic [15:0] rd_v;
        int lat;
        access(1'b0, 1'b0, 1'b1, be, a, d, perturb, rd_v, lat);
        check("wr_latency", lat, 3);
        check("rdata_hold_on_write", {16'd0, rd_v}, {16'd0, last_rd});
        model[a[8:1]] = merge(model[a[8:1]], d, be);
    endtask

    task automatic rd3(input string tag, input logic [15:0] a, input bit both);
        logic [15:0] rd_v;
        int lat;
        access(1'b0, 1'b1, both, 2'b11, a, 16'h5555, 1'b0, rd_v, lat);
        check("rd_latency", lat, 3);
        check(tag, {16'd0, rd_v}, {16'd0, model[a[8:1]]});
        last_rd = model[a[8:1]];
    endtask

    initial begin
        logic [15:0] a, d, rv;
        int lat, op;
        b3.mem_read = 0; b3.mem_write = 0; b3.mem_byte_enable = 0; b3.mem_address = 0; b3.mem_wdata = 0;
        b1.mem_read = 0; b1.mem_write = 0; b1.mem_byte_enable = 0; b1.mem_address = 0; b1.mem_wdata = 0;
        for (int i = 0; i < 256; i++) model[i] = 16'h0000;
        last_rd = 16'h0000;
        repeat (3) @(negedge clk);
        check("rst_resp", {31'd0, b3.mem_resp}, 32'd0);
        check("rst_rdata", {16'd0, b3.mem_rdata}, 32'd0);
        check("rst_perr", {31'd0, b3.proto_err}, 32'd0);
        check("rst_resp_l1", {31'd0, b1.mem_resp}, 32'd0);
        rst_n = 1'b1;

        // Basic write then read-back.
        wr3(16'h0010, 16'hBEEF, 2'b11, 1'b0);
        rd3("t1_beef", 16'h0010, 1'b0);
        check("t1_value", {16'd0, last_rd}, 32'h0000BEEF);

        // Byte-lane merging within one word, bit 0 of the address ignored.
        wr3(16'h0020, 16'h1234, 2'b11, 1'b0);
        wr3(16'h0021, 16'hAB00, 2'b10, 1'b0);
        wr3(16'h0021, 16'h00CD, 2'b01, 1'b0);
        rd3("t2_abcd", 16'h0020, 1'b0);
        check("t2_value", {16'd0, last_rd}, 32'h0000ABCD);

        // LATENCY=1 instance: back-to-back reads with mem_read held high.
        access(1'b1, 1'b0, 1'b1, 2'b11, 16'h0000, 16'hA1A1, 1'b0, rv, lat);
        check("l1_wr_lat", lat, 1);
        access(1'b1, 1'b0, 1'b1, 2'b11, 16'h0002, 16'hB2B2, 1'b0, rv, lat);
        @(negedge clk);
        b1.mem_read = 1'b1; b1.mem_address = 16'h0000;
        @(negedge clk);
        check("l1_resp_a", {31'd0, b1.mem_resp}, 32'd1);
        check("l1_data_a", {16'd0, b1.mem_rdata}, 32'h0000A1A1);
        b1.mem_address = 16'h0002;
        @(negedge clk);
        check("l1_idle_gap", {31'd0, b1.mem_resp}, 32'd0);
        @(negedge clk);
        check("l1_resp_b", {31'd0, b1.mem_resp}, 32'd1);
        check("l1_data_b", {16'd0, b1.mem_rdata}, 32'h0000B2B2);
        b1.mem_read = 1'b0;
        @(negedge clk);
        check("l1_end", {31'd0, b1.mem_resp}, 32'd0);

        // Read and write together: serviced as read, sticky protocol error.
        wr3(16'h0040, 16'h2222, 2'b11, 1'b0);
        check("t4_perr_before", {31'd0, b3.proto_err}, 32'd0);
        rd3("t4_both_rdata", 16'h0040, 1'b1);
        check("t4_perr_set", {31'd0, b3.proto_err}, 32'd1);
        rd3("t4_unchanged", 16'h0040, 1'b0);
        check("t4_perr_sticky", {31'd0, b3.proto_err}, 32'd1);

        // Reset during WAIT of a write drops the write.
        wr3(16'h0030, 16'h0001, 2'b11, 1'b0);
        @(negedge clk);
        b3.mem_write = 1'b1; b3.mem_byte_enable = 2'b11; b3.mem_address = 16'h0030; b3.mem_wdata = 16'hFFFF;
        @(negedge clk);
        rst_n = 1'b0;
        b3.mem_write = 1'b0;
        #1;
        check("t5_resp", {31'd0, b3.mem_resp}, 32'd0);
        check("t5_rdata", {16'd0, b3.mem_rdata}, 32'd0);
        check("t5_perr", {31'd0, b3.proto_err}, 32'd0);
        @(negedge clk);
        check("t5_resp_hold", {31'd0, b3.mem_resp}, 32'd0);
        rst_n = 1'b1;
        last_rd = 16'h0000;
        rd3("t5_old_value", 16'h0030, 1'b0);
        check("t5_value", {16'd0, last_rd}, 32'h00000001);

        // Inputs changed during WAIT are ignored; upper address bits alias.
        wr3(16'h0202, 16'h7E57, 2'b11, 1'b1);
        rd3("t6_alias", 16'h0002, 1'b0);
        check("t6_value", {16'd0, last_rd}, 32'h00007E57);

        // Randomized traffic against the model over words 0x60..0x6F.
        for (int i = 0; i < 16; i++) begin
            a = 16'h00C0 + 16'(i * 2);
            wr3(a, 16'($urandom), 2'b11, 1'b0);
        end
        for (int i = 0; i < 40; i++) begin
            a = 16'($urandom);
            a[8:1] = 8'h60 + 8'($urandom_range(0, 15));
            d = 16'($urandom);
            op = $urandom_range(0, 4);
            if (op <= 1)      rd3("rnd_read", a, 1'b0);
            else if (op == 4) rd3("rnd_both", a, 1'b1);
            else              wr3(a, d, 2'($urandom), 1'($urandom));
        end
        for (int i = 0; i < 16; i++) begin
            a = 16'h00C0 + 16'(i * 2);
            rd3("rnd_final", a, 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule
